demux1to2_buf: RTL and testbench

- Registered 1-to-2 data router: the inverse of the datapath 2-to-1 select. One producer word is steered to one of two consumer channels by Sel.
- Each output channel has a one-entry buffer with valid/ready handshake.
- Used to route a shared result or memory-response stream to either the fetch or the load path without combinational paths through consumers' data.

---
 rtl/mips_defs.sv | 10 +
 rtl/demux_out_buf.sv | 50 +++++
 rtl/demux1to2_buf.sv | 88 ++++++++
 tb/tb_demux1to2_buf.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the datapath routing blocks: channel select
// encodings and the default datapath word width.
package mips_defs;

  localparam int WORD_W = 32;

  localparam logic SEL_CH1 = 1'b0;
  localparam logic SEL_CH2 = 1'b1;

endpackage : mips_defs

// File: rtl/demux_out_buf.sv
// One-entry output buffer with valid/ready handshake. A word loaded while the
// current one drains replaces it in the same edge, sustaining 1 word/cycle.
module demux_out_buf
  import mips_defs::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadEn,
  input  logic [WIDTH-1:0] DIn,
  input  logic             Ready,
  output logic             Valid,
  output logic [WIDTH-1:0] DOut,
  output logic             Free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // NOTE: every signal written here gets its default first; a path that skips
  // an assignment in always_comb would otherwise infer a latch.
  always_comb begin
    valid_d = valid_q & ~Ready;
    data_d  = data_q;
    if (LoadEn) begin
      valid_d = 1'b1;
      data_d  = DIn;
    end
  end

  // NOTE: the data register is reset too, because Dout must read 0 out of
  // reset; it is a single word, not a memory array.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign Valid = valid_q;
  assign DOut  = data_q;
  assign Free  = ~valid_q | Ready;

endmodule : demux_out_buf

// File: rtl/demux1to2_buf.sv
// Registered 1-to-2 router: Sel steers each accepted word into one of two
// buffered channels. Define DEMUX_COUNT_EN to add per-channel accept counters.
module demux1to2_buf
  import mips_defs::*;
#(
  parameter int WIDTH = WORD_W
`ifdef DEMUX_COUNT_EN
  ,
  parameter int COUNT_W = 16
`endif
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Din,
  input  logic               Sel,
  input  logic               InValid,
  output logic               InReady,
  output logic [WIDTH-1:0]   Dout1,
  output logic               Valid1,
  input  logic               Ready1,
  output logic [WIDTH-1:0]   Dout2,
  output logic               Valid2,
  input  logic               Ready2
`ifdef DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] Count1,
  output logic [COUNT_W-1:0] Count2
`endif
);

  logic free1, free2;
  logic accept, load1, load2;

  // Only the selected channel can stall the producer.
  assign InReady = (Sel == SEL_CH2) ? free2 : free1;
  assign accept  = InValid & InReady;
  assign load1   = accept & (Sel == SEL_CH1);
  assign load2   = accept & (Sel == SEL_CH2);

  demux_out_buf #(.WIDTH(WIDTH)) u_buf1 (
    .Clk    (Clk),
    .Reset  (Reset),
    .LoadEn (load1),
    .DIn    (Din),
    .Ready  (Ready1),
    .Valid  (Valid1),
    .DOut   (Dout1),
    .Free   (free1)
  );

  demux_out_buf #(.WIDTH(WIDTH)) u_buf2 (
    .Clk    (Clk),
    .Reset  (Reset),
    .LoadEn (load2),
    .DIn    (Din),
    .Ready  (Ready2),
    .Valid  (Valid2),
    .DOut   (Dout2),
    .Free   (free2)
  );

`ifdef DEMUX_COUNT_EN
  logic [COUNT_W-1:0] count1_q, count1_d;
  logic [COUNT_W-1:0] count2_q, count2_d;

  // Counters wrap naturally from all-ones to zero.
  always_comb begin
    count1_d = count1_q;
    count2_d = count2_q;
    if (load1) count1_d = count1_q + COUNT_W'(1);
    if (load2) count2_d = count2_q + COUNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count1_q <= '0;
      count2_q <= '0;
    end else begin
      count1_q <= count1_d;
      count2_q <= count2_d;
    end
  end

  assign Count1 = count1_q;
  assign Count2 = count2_q;
`endif

endmodule : demux1to2_buf

// File: tb/tb_demux1to2_buf.sv
// Scoreboard bench for demux1to2_buf: accepted words are queued per channel
// and compared in order as each channel drains.
module tb_demux1to2_buf;

  localparam int WIDTH = 32;
`ifdef DEMUX_COUNT_EN
  localparam int COUNT_W = 4;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] Din;
  logic             Sel;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] Dout1, Dout2;
  logic             Valid1, Valid2;
  logic             Ready1, Ready2;
`ifdef DEMUX_COUNT_EN
  logic [COUNT_W-1:0] Count1, Count2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];

  always #5 Clk = ~Clk;

  demux1to2_buf #(
    .WIDTH(WIDTH)
`ifdef DEMUX_COUNT_EN
    , .COUNT_W(COUNT_W)
`endif
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Din     (Din),
    .Sel     (Sel),
    .InValid (InValid),
    .InReady (InReady),
    .Dout1   (Dout1),
    .Valid1  (Valid1),
    .Ready1  (Ready1),
    .Dout2   (Dout2),
    .Valid2  (Valid2),
    .Ready2  (Ready2)
`ifdef DEMUX_COUNT_EN
    , .Count1 (Count1)
    , .Count2 (Count2)
`endif
  );

  // Record handshakes just before the edge, then advance to edge + 1.
  task automatic tick();
    logic [WIDTH-1:0] exp;
    if (InValid && InReady) begin
      if (Sel) q2.push_back(Din);
      else     q1.push_back(Din);
    end
    if (Valid1 && Ready1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_errors++;
        $display("FAIL sb_ch1_unexpected: got Dout1=%h, expected no word", Dout1);
      end else begin
        exp = q1.pop_front();
        if (Dout1 !== exp) begin
          n_errors++;
          $display("FAIL sb_ch1_data: got %h, expected %h", Dout1, exp);
        end
      end
    end
    if (Valid2 && Ready2) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_errors++;
        $display("FAIL sb_ch2_unexpected: got Dout2=%h, expected no word", Dout2);
      end else begin
        exp = q2.pop_front();
        if (Dout2 !== exp) begin
          n_errors++;
          $display("FAIL sb_ch2_data: got %h, expected %h", Dout2, exp);
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; Din = '0; Sel = 1'b0; Ready1 = 1'b0; Ready2 = 1'b0;
    #2;
    n_checks++;
    if ({Valid1, Valid2, Dout1, Dout2} !== '0 || InReady !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: got V1=%b V2=%b D1=%h D2=%h InReady=%b, expected 0 0 0 0 1",
               Valid1, Valid2, Dout1, Dout2, InReady);
    end
    @(posedge Clk); #3; Reset = 1'b0;
    @(posedge Clk); #1;
    // Stall a word in ch1, then reset mid-cycle.
    Sel = 1'b0; Din = 32'hDEADBEEF; InValid = 1'b1; Ready1 = 1'b0;
    tick();
    InValid = 1'b0;
    n_checks++;
    if (Valid1 !== 1'b1 || Dout1 !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL reset_preload: got V1=%b D1=%h, expected 1 deadbeef", Valid1, Dout1);
    end
    #3; Reset = 1'b1; #1;
    n_checks++;
    if (Valid1 !== 1'b0 || Dout1 !== '0) begin
      n_errors++;
      $display("FAIL reset_async: got V1=%b D1=%h, expected 0 00000000", Valid1, Dout1);
    end
    q1.delete(); q2.delete();
    @(posedge Clk); #3; Reset = 1'b0;
    @(posedge Clk); #1;
    n_checks++;
    if (InReady !== 1'b1 || Valid1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got InReady=%b V1=%b, expected 1 0", InReady, Valid1);
    end
  endtask

  task automatic test_single();
    Sel = 1'b0; Din = 32'h11; InValid = 1'b1; Ready1 = 1'b1; Ready2 = 1'b0;
    #1;
    n_checks++;
    if (InReady !== 1'b1) begin
      n_errors++;
      $display("FAIL single_inready: got %b, expected 1", InReady);
    end
    tick();
    InValid = 1'b0;
    n_checks++;
    if (Valid1 !== 1'b1 || Dout1 !== 32'h11 || Valid2 !== 1'b0) begin
      n_errors++;
      $display("FAIL single_out: got V1=%b D1=%h V2=%b, expected 1 00000011 0", Valid1, Dout1, Valid2);
    end
    tick();
    n_checks++;
    if (Valid1 !== 1'b0 || Dout1 !== 32'h11 || Valid2 !== 1'b0) begin
      n_errors++;
      $display("FAIL single_drained: got V1=%b D1=%h V2=%b, expected 0 00000011 0", Valid1, Dout1, Valid2);
    end
  endtask

  task automatic test_backpressure();
    Sel = 1'b1; Ready2 = 1'b0; Din = 32'hA; InValid = 1'b1;
    #1;
    n_checks++;
    if (InReady !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_first_ready: got %b, expected 1", InReady);
    end
    tick();
    Din = 32'hB;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (InReady !== 1'b0 || Valid2 !== 1'b1 || Dout2 !== 32'hA) begin
        n_errors++;
        $display("FAIL bp_stall[%0d]: got InReady=%b V2=%b D2=%h, expected 0 1 0000000a",
                 i, InReady, Valid2, Dout2);
      end
      if (i == 0) tick();
    end
    Ready2 = 1'b1;
    #1;
    n_checks++;
    if (InReady !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release_ready: got %b, expected 1", InReady);
    end
    tick();
    InValid = 1'b0;
    n_checks++;
    if (Valid2 !== 1'b1 || Dout2 !== 32'hB) begin
      n_errors++;
      $display("FAIL bp_second_word: got V2=%b D2=%h, expected 1 0000000b", Valid2, Dout2);
    end
    tick();
    n_checks++;
    if (Valid2 !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drained: got V2=%b, expected 0", Valid2);
    end
  endtask

  task automatic test_nonblocking();
    Sel = 1'b1; Ready2 = 1'b0; Din = 32'h5; InValid = 1'b1;
    tick();
    Sel = 1'b0; Din = 32'h7; Ready1 = 1'b1;
    #1;
    n_checks++;
    if (InReady !== 1'b1) begin
      n_errors++;
      $display("FAIL nb_inready: got %b, expected 1", InReady);
    end
    tick();
    InValid = 1'b0;
    n_checks++;
    if (Valid1 !== 1'b1 || Dout1 !== 32'h7 || Valid2 !== 1'b1 || Dout2 !== 32'h5) begin
      n_errors++;
      $display("FAIL nb_both: got V1=%b D1=%h V2=%b D2=%h, expected 1 00000007 1 00000005",
               Valid1, Dout1, Valid2, Dout2);
    end
    tick();
    n_checks++;
    if (Valid1 !== 1'b0 || Valid2 !== 1'b1 || Dout2 !== 32'h5) begin
      n_errors++;
      $display("FAIL nb_ch2_held: got V1=%b V2=%b D2=%h, expected 0 1 00000005", Valid1, Valid2, Dout2);
    end
    Ready2 = 1'b1;
    tick();
    Ready2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    Sel = 1'b0; Ready1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      Din = WIDTH'(i); InValid = 1'b1;
      tick();
      n_checks++;
      if (Valid1 !== 1'b1 || Dout1 !== WIDTH'(i)) begin
        n_errors++;
        $display("FAIL b2b_word[%0d]: got V1=%b D1=%h, expected 1 %h", i, Valid1, Dout1, WIDTH'(i));
      end
    end
    InValid = 1'b0;
    tick();
    n_checks++;
    if (Valid1 !== 1'b0 || q1.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_end: got V1=%b pending=%0d, expected 0 0", Valid1, q1.size());
    end
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_counters();
    #3; Reset = 1'b1; #1;
    q1.delete(); q2.delete();
    @(posedge Clk); #3; Reset = 1'b0;
    @(posedge Clk); #1;
    Ready1 = 1'b1; Ready2 = 1'b1; InValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Sel = (i < 17); Din = WIDTH'(32'h100 + i);
      tick();
    end
    InValid = 1'b0;
    tick();
    n_checks++;
    if (Count2 !== 4'd1 || Count1 !== 4'd3) begin
      n_errors++;
      $display("FAIL counters: got Count1=%0d Count2=%0d, expected 3 1", Count1, Count2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_nonblocking();
    test_back_to_back();
`ifdef DEMUX_COUNT_EN
    test_counters();
`endif
    n_checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got ch1=%0d ch2=%0d pending words, expected 0 0", q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_demux1to2_buf
